// File: rtl/fetch_aligner.sv
// fetch_aligner
//   Sits between the I-cache port and the RV32IC instruction-fetch stage.
//   Reads word-aligned 32-bit lines, splits them into a halfword queue and
//   presents one whole instruction (16-bit or 32-bit, possibly straddling a
//   word boundary) per cycle together with its PC. Handles halfword-aligned
//   branch redirects, including redirects while a cache access is stalled.
//
// Parameters
//   RESET_PC  fetch PC after reset (bit0 must be 0)
//   HW_DEPTH  halfword queue depth (even, >= 4)
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   redirect        flush queue and restart fetch at redirect_pc
//   redirect_pc     new PC, halfword aligned (bit0 ignored)
//   consume         IF stage takes the current instruction
//   out_valid       out_inst/out_pc/out_is16 hold a complete instruction
//   out_pc          PC of out_inst
//   out_inst        {16'h0,hw0} for compressed, {hw1,hw0} for 32-bit
//   out_is16        instruction is compressed (hw0[1:0] != 2'b11)
//   ic_ren/ic_addr  registered I-cache request (word address PC[31:2])
//   ic_rdata        I-cache data, valid when ic_ren && !ic_stall
//   ic_stall        I-cache busy; request is held while high
//
// Configuration
//   BYTE_SWAP_EN    when defined, ic_rdata is byte-reversed before the
//                   halfword split (big-endian cache image).

module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          HW_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        consume,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_is16,
  output logic        ic_ren,
  output logic [29:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_stall
);

  localparam int CW = $clog2(HW_DEPTH + 1);
  localparam int QW = HW_DEPTH * 16;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                    r_state;
  logic [HW_DEPTH-1:0][15:0] r_q;        // slot 0 is the queue head
  logic [CW-1:0]             r_count;
  logic [31:0]               r_out_pc;
  logic [31:0]               r_fetch_pc;
  logic                      r_skip_lo;
  logic                      r_ic_ren;
  logic [29:0]               r_ic_addr;

  logic [31:0]               w_rdata;
  logic [15:0]               w_hw0, w_hw1, w_first;
  logic                      w_is16, w_valid, w_pop, w_accept, w_inflight, w_req;
  logic [1:0]                w_pop_n, w_push_n;
  logic [CW-1:0]             w_wp, w_cnt_nxt;
  logic [HW_DEPTH-1:0][15:0] w_sh, w_q_nxt;
  logic [QW-1:0]             w_ins, w_msk;
  logic [31:0]               w_fetch_nxt;

`ifdef BYTE_SWAP_EN
  assign w_rdata = {ic_rdata[7:0], ic_rdata[15:8], ic_rdata[23:16], ic_rdata[31:24]};
`else
  assign w_rdata = ic_rdata;
`endif

  // Instruction decode straight off the registered queue head
  assign w_hw0   = r_q[0];
  assign w_hw1   = r_q[1];
  assign w_is16  = (w_hw0[1:0] != 2'b11);
  assign w_valid = ((r_count >= CW'(1)) && w_is16) || (r_count >= CW'(2));

  assign out_valid = w_valid;
  assign out_pc    = r_out_pc;
  assign out_is16  = w_is16;
  assign out_inst  = w_is16 ? {16'h0, w_hw0} : {w_hw1, w_hw0};
  assign ic_ren    = r_ic_ren;
  assign ic_addr   = r_ic_addr;

  // A stalled request must not move; a redirect then has to wait it out
  assign w_inflight = r_ic_ren && ic_stall;
  assign w_accept   = r_ic_ren && !ic_stall && (r_state == ST_RUN) && !redirect;
  assign w_pop      = w_valid && consume && !redirect;
  assign w_pop_n    = !w_pop ? 2'd0 : (w_is16 ? 2'd1 : 2'd2);
  assign w_push_n   = !w_accept ? 2'd0 : (r_skip_lo ? 2'd1 : 2'd2);

  // Write pointer is the post-pop fill level, so push and pop can coexist
  assign w_wp      = r_count - CW'(w_pop_n);
  assign w_cnt_nxt = w_wp + CW'(w_push_n);
  assign w_first   = r_skip_lo ? w_rdata[31:16] : w_rdata[15:0];

  // Requesting only with two free slots guarantees a returned word always fits
  assign w_req       = (w_cnt_nxt <= CW'(HW_DEPTH - 2));
  assign w_fetch_nxt = w_accept ? r_fetch_pc + 32'd4 : r_fetch_pc;

  always_comb begin
    case (w_pop_n)
      2'd1:    w_sh = {16'h0, r_q[HW_DEPTH-1:1]};
      2'd2:    w_sh = {32'h0, r_q[HW_DEPTH-1:2]};
      default: w_sh = r_q;
    endcase
    // After a skipped low half only one halfword lands, at the write pointer
    w_ins = QW'({w_rdata[31:16], w_first}) << {w_wp, 4'd0};
    w_msk = '0;
    if (w_accept)
      w_msk = QW'({(r_skip_lo ? 16'h0000 : 16'hFFFF), 16'hFFFF}) << {w_wp, 4'd0};
    w_q_nxt = (w_sh & ~w_msk) | (w_ins & w_msk);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_q        <= '0;
      r_count    <= '0;
      r_out_pc   <= RESET_PC;
      r_fetch_pc <= RESET_PC & ~32'd3;
      r_skip_lo  <= RESET_PC[1];
      r_ic_ren   <= 1'b0;
      r_ic_addr  <= RESET_PC[31:2];
    end else if (redirect) begin
      r_q        <= '0;
      r_count    <= '0;
      r_out_pc   <= redirect_pc & ~32'd1;
      r_fetch_pc <= redirect_pc & ~32'd3;
      r_skip_lo  <= redirect_pc[1];
      if (w_inflight) begin
        // Old request stays on the bus; its data is dropped when it completes
        r_state <= ST_FLUSH;
      end else begin
        r_state   <= ST_RUN;
        r_ic_ren  <= 1'b1;
        r_ic_addr <= redirect_pc[31:2];
      end
    end else if (r_state == ST_FLUSH) begin
      // Stale word returns this cycle and is ignored; re-arm at the new target
      if (!ic_stall) begin
        r_state   <= ST_RUN;
        r_ic_ren  <= 1'b1;
        r_ic_addr <= r_fetch_pc[31:2];
      end
    end else begin
      r_q        <= w_q_nxt;
      r_count    <= w_cnt_nxt;
      r_fetch_pc <= w_fetch_nxt;
      if (w_accept)
        r_skip_lo <= 1'b0;
      if (w_pop)
        r_out_pc <= r_out_pc + (w_is16 ? 32'd2 : 32'd4);
      if (!w_inflight) begin
        r_ic_ren  <= w_req;
        r_ic_addr <= w_fetch_nxt[31:2];
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed table, hand-written
// multi-cycle sequences, and a randomized run against a PC-level model that
// parses the memory image halfword by halfword.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        consume = 1'b1;
  logic        ic_stall = 1'b0;
  logic        out_valid, out_is16, ic_ren;
  logic [31:0] out_pc, out_inst, ic_rdata;
  logic [29:0] ic_addr;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  fetch_aligner #(.RESET_PC(32'h0000_0000), .HW_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .consume(consume), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_is16(out_is16), .ic_ren(ic_ren),
    .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_stall(ic_stall)
  );

  always #5 clk = ~clk;

  assign ic_rdata = mem[ic_addr[9:0]];

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Little-endian view of a memory word, as the fetch stage interprets it
  function automatic logic [31:0] word_at(input logic [9:0] idx);
`ifdef BYTE_SWAP_EN
    return swap32(mem[idx]);
`else
    return mem[idx];
`endif
  endfunction

  task automatic mem_wr(input logic [9:0] idx, input logic [31:0] w);
`ifdef BYTE_SWAP_EN
    mem[idx] = swap32(w);
`else
    mem[idx] = w;
`endif
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a[11:2]);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: the instruction located at pc by RV32IC length rules
  task automatic ref_inst(input logic [31:0] pc, output logic [31:0] inst,
                          output logic is16, output logic [31:0] len);
    logic [15:0] h0;
    h0 = hw_at(pc);
    if (h0[1:0] != 2'b11) begin
      inst = {16'h0, h0}; is16 = 1'b1; len = 32'd2;
    end else begin
      inst = {hw_at(pc + 32'd2), h0}; is16 = 1'b0; len = 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a valid instruction, compare it, and let consume pop it
  task automatic expect_inst(input string nm, input logic [31:0] pc,
                             input logic [31:0] inst, input logic is16);
    int k;
    k = 0;
    while (!out_valid && k < 12) begin
      step;
      k++;
    end
    chk({nm, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({nm, "_pc"}, out_pc, pc);
    chk({nm, "_inst"}, out_inst, inst);
    chk({nm, "_is16"}, {31'h0, out_is16}, {31'h0, is16});
    step;
  endtask

  typedef struct {
    logic [31:0] tgt, w0, w1;
    logic        v2;
    logic [31:0] pc0, i0;
    logic        s0;
    logic [31:0] pc1, i1;
    logic        s1;
  } vec_t;

  vec_t tv [7];

  initial begin
    logic [9:0]  ix;
    logic [31:0] mpc, ei, elen, p_addr;
    logic        es, prev_hold;
    int          pops;

    tv[0] = '{32'h0000_0010, 32'h4501_4505, 32'h0000_0000, 1'b1, 32'h10, 32'h4505, 1'b1, 32'h12, 32'h4501, 1'b1};
    tv[1] = '{32'h0000_0020, 32'h0093_4505, 32'hABCD_0010, 1'b1, 32'h20, 32'h4505, 1'b1, 32'h22, 32'h0010_0093, 1'b0};
    tv[2] = '{32'h0000_0102, 32'h4509_0001, 32'h0000_0013, 1'b1, 32'h102, 32'h4509, 1'b1, 32'h104, 32'h13, 1'b0};
    tv[3] = '{32'h0000_0202, 32'h0513_1234, 32'h8082_00A5, 1'b0, 32'h202, 32'h00A5_0513, 1'b0, 32'h206, 32'h8082, 1'b1};
    tv[4] = '{32'h0000_0300, 32'hFFFF_0000, 32'h1234_5678, 1'b1, 32'h300, 32'h0, 1'b1, 32'h302, 32'h5678_FFFF, 1'b0};
    tv[5] = '{32'h0000_0501, 32'h4501_4505, 32'h0000_0000, 1'b1, 32'h500, 32'h4505, 1'b1, 32'h502, 32'h4501, 1'b1};
    tv[6] = '{32'hFFFF_FFFE, 32'h4505_0000, 32'h0000_0013, 1'b1, 32'hFFFF_FFFE, 32'h4505, 1'b1, 32'h0, 32'h13, 1'b0};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem_wr(10'h0, 32'h0000_0013);
    mem_wr(10'h1, 32'h0000_0013);

    // Reset state
    #12;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_ren", {31'h0, ic_ren}, 32'h0);
    chk("rst_addr", {2'b0, ic_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // First fetch after reset: request at cycle 1, instruction at cycle 2
    step;
    chk("c1_ren", {31'h0, ic_ren}, 32'h1);
    chk("c1_addr", {2'b0, ic_addr}, 32'h0);
    chk("c1_valid", {31'h0, out_valid}, 32'h0);
    step;
    chk("c2_valid", {31'h0, out_valid}, 32'h1);
    chk("c2_inst", out_inst, 32'h13);
    chk("c2_is16", {31'h0, out_is16}, 32'h0);
    chk("c2_pc", out_pc, 32'h0);
    step;
    chk("c3_pc", out_pc, 32'h4);

    // Directed redirect table
    for (int t = 0; t < 7; t++) begin
      ix = tv[t].tgt[11:2];
      mem_wr(ix, tv[t].w0);
      mem_wr(ix + 10'd1, tv[t].w1);
      redirect = 1'b1; redirect_pc = tv[t].tgt; consume = 1'b1; ic_stall = 1'b0;
      step;
      redirect = 1'b0;
      chk($sformatf("t%0d_ren", t), {31'h0, ic_ren}, 32'h1);
      chk($sformatf("t%0d_addr", t), {2'b0, ic_addr}, {2'b0, tv[t].tgt[31:2]});
      chk($sformatf("t%0d_flushed", t), {31'h0, out_valid}, 32'h0);
      step;
      chk($sformatf("t%0d_lat", t), {31'h0, out_valid}, {31'h0, tv[t].v2});
      expect_inst($sformatf("t%0d_a", t), tv[t].pc0, tv[t].i0, tv[t].s0);
      expect_inst($sformatf("t%0d_b", t), tv[t].pc1, tv[t].i1, tv[t].s1);
    end

    // Redirects while a stalled access is in flight
    mem_wr(10'h10, 32'h1111_1111);
    mem_wr(10'h30, 32'h4501_4505);
    mem_wr(10'h31, 32'h0000_0000);
    redirect = 1'b1; redirect_pc = 32'h40; ic_stall = 1'b0;
    step;
    redirect = 1'b0; ic_stall = 1'b1;
    chk("fl_ren0", {31'h0, ic_ren}, 32'h1);
    chk("fl_addr0", {2'b0, ic_addr}, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h80;
    step;
    redirect = 1'b0;
    chk("fl_addr1", {2'b0, ic_addr}, 32'h10);
    redirect = 1'b1; redirect_pc = 32'hC2;
    step;
    redirect = 1'b0;
    chk("fl_addr2", {2'b0, ic_addr}, 32'h10);
    chk("fl_ren2", {31'h0, ic_ren}, 32'h1);
    step;
    chk("fl_addr3", {2'b0, ic_addr}, 32'h10);
    chk("fl_valid3", {31'h0, out_valid}, 32'h0);
    ic_stall = 1'b0;
    step;
    chk("fl_rearm_ren", {31'h0, ic_ren}, 32'h1);
    chk("fl_rearm_addr", {2'b0, ic_addr}, 32'h30);
    chk("fl_discard", {31'h0, out_valid}, 32'h0);
    step;
    chk("fl_out_valid", {31'h0, out_valid}, 32'h1);
    chk("fl_out_pc", out_pc, 32'hC2);
    chk("fl_out_inst", out_inst, 32'h4501);

    // Back-pressure: queue fills, fetch stops, then drains without gaps
    for (int i = 0; i < 16; i++)
      mem_wr(10'h100 + 10'(i), {14'(2*i+1), 2'b01, 14'(2*i), 2'b01});
    redirect = 1'b1; redirect_pc = 32'h400; consume = 1'b0;
    step;
    redirect = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c >= 12) begin
        chk($sformatf("full_ren%0d", c), {31'h0, ic_ren}, 32'h0);
        chk($sformatf("full_valid%0d", c), {31'h0, out_valid}, 32'h1);
      end
      step;
    end
    consume = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_valid%0d", k), {31'h0, out_valid}, 32'h1);
      chk($sformatf("drain_pc%0d", k), out_pc, 32'h400 + 32'(2*k));
      chk($sformatf("drain_inst%0d", k), out_inst, {16'h0, 14'(k), 2'b01});
      step;
    end

`ifdef BYTE_SWAP_EN
    mem[10'h200] = 32'h1300_0000;
    mem[10'h201] = 32'h0000_0000;
    redirect = 1'b1; redirect_pc = 32'h800;
    step;
    redirect = 1'b0;
    step;
    chk("swap_valid", {31'h0, out_valid}, 32'h1);
    chk("swap_inst", out_inst, 32'h0000_0013);
`endif

    // Randomized run against the PC-level model
    for (int i = 0; i < 1024; i++) mem_wr(10'(i), $urandom());
    mpc = 32'h800;
    redirect = 1'b1; redirect_pc = mpc; consume = 1'b0; ic_stall = 1'b0;
    step;
    redirect = 1'b0;
    prev_hold = 1'b0; p_addr = 32'h0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_hold) begin
        chk("hold_ren", {31'h0, ic_ren}, 32'h1);
        chk("hold_addr", {2'b0, ic_addr}, p_addr);
      end
      redirect    = ($urandom_range(0, 99) < 3);
      redirect_pc = $urandom();
      consume     = ($urandom_range(0, 99) < 70);
      ic_stall    = ($urandom_range(0, 99) < 30);
      if (!redirect && out_valid && consume) begin
        ref_inst(mpc, ei, es, elen);
        chk("rnd_pc", out_pc, mpc);
        chk("rnd_inst", out_inst, ei);
        chk("rnd_is16", {31'h0, out_is16}, {31'h0, es});
        mpc = mpc + elen;
        pops++;
      end
      if (redirect) mpc = redirect_pc & ~32'd1;
      prev_hold = ic_ren && ic_stall;
      p_addr = {2'b0, ic_addr};
      step;
    end
    redirect = 1'b0; ic_stall = 1'b0;
    chk("rnd_progress", {31'h0, pops > 300}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
